// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32I controller.
// Holds the opcode constants, immediate-extender codes (I/S/B/J/U), ALU
// operation codes, datapath select encodings, the main FSM state type and
// the branch-condition helper used by the BRANCH state.
package multicycle_controller_pkg;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Immediate extender format codes
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // Main FSM states; the spare 4-bit codes are unreachable
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_LUI      = 4'd8,
        S_JAL      = 4'd9,
        S_ALUWB    = 4'd10,
        S_BRANCH   = 4'd11
    } state_t;

    // Branch condition from the SUB result flags; unknown funct3 is never taken
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       z,
                                          input logic       n);
        logic taken;
        case (f3)
            F3_BEQ:  taken = z;
            F3_BNE:  taken = ~z;
            F3_BLT:  taken = n;
            F3_BGE:  taken = ~n;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder for the multicycle controller.
// Ports:
//   opcode      in  7  instruction opcode (selects SUB only for R-type)
//   funct3      in  3  instruction funct3
//   funct7b5    in  1  instr[30], SUB qualifier for R-type
//   alu_control out 3  ALU operation code
//   illegal     out 1  funct3 has no supported ALU operation
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    // funct3 -> ALU op; funct7b5 only means SUB for register-register ops
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (funct3)
            3'b000: begin
                if ((opcode == OP_RTYPE) && funct7b5) begin
                    alu_control = ALU_SUB;
                end else begin
                    alu_control = ALU_ADD;
                end
            end
            3'b111:  alu_control = ALU_AND;
            3'b110:  alu_control = ALU_OR;
            3'b100:  alu_control = ALU_XOR;
            3'b010:  alu_control = ALU_SLT;
            default: begin
                alu_control = ALU_ADD;
                illegal     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of the multicycle RV32I core.
// Sequences the shared ALU/memory datapath over 3-5 cycles per instruction
// and owns every PC/IR/regfile/memory write enable.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   opcode/funct3/funct7b5   latched instruction fields from IR
//   zero, neg         ALU result flags of the current cycle
//   memReady          memory completes its access this cycle
//   pcWrite, memWrite, irWrite, regWrite   write enables
//   adrSrc, resultSrc, aluSrcA, aluSrcB    datapath mux selects
//   immSrc, aluControl                     extender format, ALU op
//   instrDone, illegalInstr                single-cycle status pulses
// Outputs are combinational from the state and current inputs.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       neg,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] immSrc,
    output logic [2:0] aluControl,
    output logic       instrDone,
    output logic       illegalInstr
);

    state_t     state_r;
    state_t     next_state_s;
    logic [2:0] alu_dec_s;
    logic       alu_illegal_s;
    logic       pc_write_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       instr_done_s;
    logic       illegal_instr_s;

    alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_dec_s),
        .illegal     (alu_illegal_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        next_state_s    = S_FETCH;
        pc_write_s      = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_write_s     = 1'b0;
        instr_done_s    = 1'b0;
        illegal_instr_s = 1'b0;
        adrSrc          = 1'b0;
        resultSrc       = RES_ALUOUT;
        aluSrcA         = SRCA_PC;
        aluSrcB         = SRCB_RS2;
        immSrc          = IMM_I;
        aluControl      = ALU_ADD;

        case (state_r)
            S_FETCH: begin
                // PC + 4 goes straight through as the result
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALU;
                if (memReady) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // oldPC + imm lands in ALUOut as the branch/jump target
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                immSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
                    OP_RTYPE, OP_IMM: begin
                        if (alu_illegal_s) begin
                            illegal_instr_s = 1'b1;
                            instr_done_s    = 1'b1;
                            next_state_s    = S_FETCH;
                        end else begin
                            next_state_s = (opcode == OP_RTYPE) ? S_EXEC_R : S_EXEC_I;
                        end
                    end
                    OP_JAL:    next_state_s = S_JAL;
                    OP_BRANCH: next_state_s = S_BRANCH;
                    OP_LUI:    next_state_s = S_LUI;
                    default: begin
                        illegal_instr_s = 1'b1;
                        instr_done_s    = 1'b1;
                        next_state_s    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                if (opcode == OP_STORE) begin
                    immSrc       = IMM_S;
                    next_state_s = S_MEMWRITE;
                end else begin
                    immSrc       = IMM_I;
                    next_state_s = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adrSrc       = 1'b1;
                next_state_s = memReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                resultSrc    = RES_MEM;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe stays up through the cycle memory accepts the write
                adrSrc      = 1'b1;
                mem_write_s = 1'b1;
                if (memReady) begin
                    instr_done_s = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_EXEC_R: begin
                aluSrcA      = SRCA_RS1;
                aluSrcB      = SRCB_RS2;
                aluControl   = alu_dec_s;
                next_state_s = S_ALUWB;
            end
            S_EXEC_I: begin
                aluSrcA      = SRCA_RS1;
                aluSrcB      = SRCB_IMM;
                immSrc       = IMM_I;
                aluControl   = alu_dec_s;
                next_state_s = S_ALUWB;
            end
            S_LUI: begin
                aluSrcA      = SRCA_ZERO;
                aluSrcB      = SRCB_IMM;
                immSrc       = IMM_U;
                next_state_s = S_ALUWB;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while oldPC + 4 is computed for rd
                aluSrcA      = SRCA_OLDPC;
                aluSrcB      = SRCB_FOUR;
                resultSrc    = RES_ALUOUT;
                pc_write_s   = 1'b1;
                next_state_s = S_ALUWB;
            end
            S_ALUWB: begin
                resultSrc    = RES_ALUOUT;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA      = SRCA_RS1;
                aluSrcB      = SRCB_RS2;
                aluControl   = ALU_SUB;
                resultSrc    = RES_ALUOUT;
                pc_write_s   = branch_taken(funct3, zero, neg);
                instr_done_s = 1'b1;
                next_state_s = S_FETCH;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    // Reset masks every enable and pulse combinationally, independent of state
    assign pcWrite      = pc_write_s      & ~rst;
    assign memWrite     = mem_write_s     & ~rst;
    assign irWrite      = ir_write_s      & ~rst;
    assign regWrite     = reg_write_s     & ~rst;
    assign instrDone    = instr_done_s    & ~rst;
    assign illegalInstr = illegal_instr_s & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: reset behaviour, a table
// of instructions with hand-derived latencies, directed multi-cycle corner
// sequences, and randomized instructions/stalls against an aggregate model.
module tb_multicycle_controller;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam int MAXC = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;
    logic       memReady = 1'b0;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, instrDone, illegalInstr;
    logic [1:0] resultSrc, aluSrcA, aluSrcB;
    logic [2:0] immSrc, aluControl;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .neg(neg), .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc),
        .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite), .resultSrc(resultSrc),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .immSrc(immSrc), .aluControl(aluControl),
        .instrDone(instrDone), .illegalInstr(illegalInstr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, adr, memw, irw, regw, done, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, alu;
    } obs_t;

    typedef struct {
        int cycles, pcw, regw, memw, ill, alu;
    } exp_t;

    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic f7, z, n;
        int cycles, pcw, regw, memw, ill;
    } vec_t;

    obs_t obs [MAXC];
    int   ncyc;
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Higher-level expectation: per-instruction totals from the ISA rules
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                   input logic z, input logic n, input int fw, input int mw);
        exp_t e;
        bit alu_ok;
        int code;
        alu_ok = (f3 == 3'd0) || (f3 == 3'd7) || (f3 == 3'd6) || (f3 == 3'd4) || (f3 == 3'd2);
        case (f3)
            3'd0: code = (op == RTYPE && f7) ? 1 : 0;
            3'd7: code = 2;
            3'd6: code = 3;
            3'd4: code = 4;
            3'd2: code = 5;
            default: code = -1;
        endcase
        e = '{cycles: fw + 2, pcw: 1, regw: 0, memw: 0, ill: 1, alu: -1};
        if ((op == RTYPE || op == OPIMM) && alu_ok) begin
            e = '{cycles: fw + 4, pcw: 1, regw: 1, memw: 0, ill: 0, alu: code};
        end else if (op == LUI) begin
            e = '{cycles: fw + 4, pcw: 1, regw: 1, memw: 0, ill: 0, alu: -1};
        end else if (op == JAL) begin
            e = '{cycles: fw + 4, pcw: 2, regw: 1, memw: 0, ill: 0, alu: -1};
        end else if (op == LOAD) begin
            e = '{cycles: fw + 5 + mw, pcw: 1, regw: 1, memw: 0, ill: 0, alu: -1};
        end else if (op == STORE) begin
            e = '{cycles: fw + 4 + mw, pcw: 1, regw: 0, memw: mw + 1, ill: 0, alu: -1};
        end else if (op == BRANCH) begin
            e = '{cycles: fw + 3, pcw: 1, regw: 0, memw: 0, ill: 0, alu: -1};
            if ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && n) || (f3 == 3'd5 && !n))
                e.pcw = 2;
        end
        return e;
    endfunction

    // Runs one instruction from FETCH; fw fetch-stall cycles, mw memory-stall cycles
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic n, input int fw, input int mw);
        bit fin = 0;
        bit is_mem;
        is_mem = (op == LOAD) || (op == STORE);
        opcode = op; funct3 = f3; funct7b5 = f7; zero = z; neg = n;
        ncyc = MAXC;
        for (int k = 0; k < MAXC; k++) begin
            if (k < fw)                     memReady = 1'b0;
            else if (k == fw)               memReady = 1'b1;
            else if (is_mem && k >= fw + 3) memReady = (k >= fw + 3 + mw);
            else                            memReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            obs[k] = '{pcWrite, adrSrc, memWrite, irWrite, regWrite, instrDone, illegalInstr,
                       resultSrc, aluSrcA, aluSrcB, immSrc, aluControl};
            if (instrDone) begin
                ncyc = k + 1;
                fin  = 1;
            end
            @(posedge clk);
            #1;
            if (fin) break;
        end
        if (!fin) chk("instr_timeout", 0, 1);
    endtask

    function automatic int cnt_pcw();
        int c = 0;
        for (int i = 0; i < ncyc; i++) c += int'(obs[i].pcw);
        return c;
    endfunction
    function automatic int cnt_regw();
        int c = 0;
        for (int i = 0; i < ncyc; i++) c += int'(obs[i].regw);
        return c;
    endfunction
    function automatic int cnt_memw();
        int c = 0;
        for (int i = 0; i < ncyc; i++) c += int'(obs[i].memw);
        return c;
    endfunction
    function automatic int cnt_ill();
        int c = 0;
        for (int i = 0; i < ncyc; i++) c += int'(obs[i].ill);
        return c;
    endfunction
    function automatic int cnt_irw();
        int c = 0;
        for (int i = 0; i < ncyc; i++) c += int'(obs[i].irw);
        return c;
    endfunction
    function automatic int cnt_adr();
        int c = 0;
        for (int i = 0; i < ncyc; i++) c += int'(obs[i].adr);
        return c;
    endfunction

    vec_t vecs [10];

    initial begin
        exp_t e;
        logic [6:0] ops [10];
        vecs[0] = '{RTYPE,  3'd0, 1'b0, 1'b0, 1'b0, 4, 1, 1, 0, 0};
        vecs[1] = '{OPIMM,  3'd7, 1'b1, 1'b0, 1'b0, 4, 1, 1, 0, 0};
        vecs[2] = '{LUI,    3'd3, 1'b0, 1'b0, 1'b0, 4, 1, 1, 0, 0};
        vecs[3] = '{LOAD,   3'd2, 1'b0, 1'b0, 1'b0, 5, 1, 1, 0, 0};
        vecs[4] = '{STORE,  3'd2, 1'b0, 1'b0, 1'b0, 4, 1, 0, 1, 0};
        vecs[5] = '{JAL,    3'd0, 1'b0, 1'b0, 1'b0, 4, 2, 1, 0, 0};
        vecs[6] = '{BRANCH, 3'd5, 1'b0, 1'b0, 1'b0, 3, 2, 0, 0, 0};
        vecs[7] = '{BRANCH, 3'd2, 1'b0, 1'b1, 1'b1, 3, 1, 0, 0, 0};
        vecs[8] = '{RTYPE,  3'd1, 1'b0, 1'b0, 1'b0, 2, 1, 0, 0, 1};
        vecs[9] = '{FENCE,  3'd0, 1'b0, 1'b0, 1'b0, 2, 1, 0, 0, 1};

        // Reset state: enables held off even with memReady high
        memReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_irWrite", int'(irWrite), 0);
        chk("rst_pcWrite", int'(pcWrite), 0);
        chk("rst_memWrite", int'(memWrite), 0);
        chk("rst_instrDone", int'(instrDone), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        memReady = 1'b0;
        @(negedge clk);
        chk("fetch_wait_irWrite", int'(irWrite), 0);
        chk("fetch_aluSrcB", int'(aluSrcB), 2);
        chk("fetch_resultSrc", int'(resultSrc), 2);
        @(posedge clk); #1;

        // Table of single instructions, no stalls
        for (int i = 0; i < 10; i++) begin
            run(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].n, 0, 0);
            chk($sformatf("tbl%0d_cycles", i), ncyc, vecs[i].cycles);
            chk($sformatf("tbl%0d_pcWrite", i), cnt_pcw(), vecs[i].pcw);
            chk($sformatf("tbl%0d_regWrite", i), cnt_regw(), vecs[i].regw);
            chk($sformatf("tbl%0d_memWrite", i), cnt_memw(), vecs[i].memw);
            chk($sformatf("tbl%0d_illegal", i), cnt_ill(), vecs[i].ill);
        end

        // add x3,x1,x2
        run(RTYPE, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("add_irWrite_c1", int'(obs[0].irw), 1);
        chk("add_aluCtl_exec", int'(obs[2].alu), 0);
        chk("add_srcA_exec", int'(obs[2].sa), 2);
        chk("add_regWrite_c4", int'(obs[3].regw), 1);
        // sub
        run(RTYPE, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
        chk("sub_aluCtl_exec", int'(obs[2].alu), 1);
        // slt immediate
        run(OPIMM, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("slti_aluCtl_exec", int'(obs[2].alu), 5);
        chk("slti_srcB_exec", int'(obs[2].sb), 1);

        // lw with 3 stall cycles in MEMREAD
        run(LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
        chk("lw_stall_cycles", ncyc, 8);
        chk("lw_stall_adrSrc_cycles", cnt_adr(), 4);
        chk("lw_regWrite_before_wb", int'(obs[6].regw), 0);
        chk("lw_regWrite_wb", int'(obs[7].regw), 1);
        chk("lw_resultSrc_wb", int'(obs[7].rs), 1);

        // sw with 2 stall cycles
        run(STORE, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2);
        chk("sw_immSrc_memadr", int'(obs[2].imm), 1);
        chk("sw_memWrite_memadr", int'(obs[2].memw), 0);
        chk("sw_memWrite_count", cnt_memw(), 3);
        chk("sw_memWrite_last", int'(obs[5].memw), 1);

        // Branches
        run(BRANCH, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("beq_taken_pcWrite", int'(obs[2].pcw), 1);
        chk("beq_decode_immSrc", int'(obs[1].imm), 2);
        chk("beq_aluCtl", int'(obs[2].alu), 1);
        run(BRANCH, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0);
        chk("bne_nottaken_pcWrite", int'(obs[2].pcw), 0);
        run(BRANCH, 3'd4, 1'b0, 1'b0, 1'b1, 0, 0);
        chk("blt_taken_pcWrite", int'(obs[2].pcw), 1);

        // jal and jalr
        run(JAL, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("jal_decode_immSrc", int'(obs[1].imm), 3);
        chk("jal_pcWrite_c3", int'(obs[2].pcw), 1);
        chk("jal_regWrite_c4", int'(obs[3].regw), 1);
        run(JALR, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("jalr_illegal_pulse", int'(obs[1].ill), 1);
        chk("jalr_cycles", ncyc, 2);

        // Reset pulse in the middle of a stalled MEMWRITE
        opcode = STORE; funct3 = 3'd2; memReady = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        memReady = 1'b0;
        @(negedge clk);
        chk("memwrite_before_rst", int'(memWrite), 1);
        #1 rst = 1'b1;
        #1;
        chk("memwrite_rst_same_cycle", int'(memWrite), 0);
        memReady = 1'b1;
        @(posedge clk); #1;
        chk("rst_hold_pcWrite", int'(pcWrite), 0);
        chk("rst_hold_irWrite", int'(irWrite), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch_irWrite", int'(irWrite), 1);
        chk("post_rst_fetch_pcWrite", int'(pcWrite), 1);
        opcode = JALR;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_decode_illegal", int'(illegalInstr), 1);
        @(posedge clk); #1;

        // Randomized instructions and stalls against the aggregate model
        ops = '{LOAD, STORE, RTYPE, OPIMM, JAL, BRANCH, LUI, JALR, FENCE, 7'd0};
        for (int t = 0; t < 150; t++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic f7, z, n;
            int fw, mw, ri;
            op = ops[$urandom_range(0, 9)];
            if (op == 7'd0) op = 7'($urandom);
            f3 = 3'($urandom); f7 = 1'($urandom); z = 1'($urandom); n = 1'($urandom);
            fw = $urandom_range(0, 3); mw = $urandom_range(0, 3);
            e = model(op, f3, f7, z, n, fw, mw);
            run(op, f3, f7, z, n, fw, mw);
            chk($sformatf("rnd%0d_op%b_cycles", t, op), ncyc, e.cycles);
            chk($sformatf("rnd%0d_op%b_pcWrite", t, op), cnt_pcw(), e.pcw);
            chk($sformatf("rnd%0d_op%b_regWrite", t, op), cnt_regw(), e.regw);
            chk($sformatf("rnd%0d_op%b_memWrite", t, op), cnt_memw(), e.memw);
            chk($sformatf("rnd%0d_op%b_illegal", t, op), cnt_ill(), e.ill);
            chk($sformatf("rnd%0d_op%b_irWrite", t, op), cnt_irw(), 1);
            if (e.alu >= 0) begin
                ri = ncyc - 1;
                chk($sformatf("rnd%0d_f3%b_aluCtl", t, f3), (ri >= 1) ? int'(obs[ri - 1].alu) : -1, e.alu);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
